// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift register controller: datapath mode codes,
// controller states and shift direction encoding.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RSP   = 2'd3
    } ctrl_state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } shift_dir_t;

    function automatic logic [1:0] dir_mode(input shift_dir_t dir);
        return (dir == DIR_RIGHT) ? MODE_SHR : MODE_SHL;
    endfunction

endpackage

// File: rtl/shift_reg_len_cnt.sv
// Loadable down-counter for the shift run length; 'last' flags the final
// shift cycle (count == 1).
module shift_reg_len_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for the universal shift register: optional parallel load,
// a programmable-length shift run, then a held response until consumed.
module shift_reg_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rx,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_p_in,
    input  logic [WIDTH-1:0] sr_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    ctrl_state_t      state_reg, state_next;
    shift_dir_t       dir_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] len_norm;
    logic             accept;
    logic             cnt_last;

    assign accept = cmd_valid && (state_reg == ST_IDLE);

    // Zero and over-range lengths both mean a full-width shift.
    always_comb begin
        len_norm = cmd_len;
        if ((cmd_len == '0) || (cmd_len > CNT_W'(WIDTH))) begin
            len_norm = CNT_W'(WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            dir_reg   <= DIR_LEFT;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                dir_reg  <= shift_dir_t'(cmd_dir);
                data_reg <= cmd_data;
            end
        end
    end

    // Counter is loaded at acceptance so it already holds len on SHIFT entry.
    shift_reg_len_cnt #(
        .CNT_W (CNT_W)
    ) u_len_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (len_norm),
        .dec      (state_reg == ST_SHIFT),
        .last     (cnt_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = cmd_rx ? ST_SHIFT : ST_LOAD;
                end
            end
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (cnt_last) begin
                    state_next = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sr_mode = MODE_HOLD;
        case (state_reg)
            ST_LOAD:  sr_mode = MODE_LOAD;
            ST_SHIFT: sr_mode = dir_mode(dir_reg);
            default:  sr_mode = MODE_HOLD;
        endcase
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign rsp_valid = (state_reg == ST_RSP);
    assign sr_p_in   = data_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rsp_gate
        assign rsp_data[gi] = sr_out[gi] & rsp_valid;
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench for shift_reg_ctrl driving a behavioural universal shift
// register; expected responses come from an arithmetic model of the command.
module tb_shift_reg_ctrl;

    localparam int W = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_rx = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [CW-1:0] cmd_len = '0;
    logic [W-1:0]  cmd_data = '0;
    logic [1:0]    sr_mode;
    logic [W-1:0]  sr_p_in;
    logic [W-1:0]  sr_q;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          busy;
    logic          s_in = 1'b0;
    logic          sr_rst;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_hs = 0;

    typedef struct {
        logic [W-1:0] data;
        int           acc;
        int           lat;
        int           stall;
    } exp_t;

    exp_t exp_q[$];
    logic [W-1:0] sr_model = '0;

    shift_reg_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rx    (cmd_rx),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .sr_mode   (sr_mode),
        .sr_p_in   (sr_p_in),
        .sr_out    (sr_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Datapath: universal shift register with active-high reset.
    assign sr_rst = ~rst_n;
    always_ff @(posedge clk or posedge sr_rst) begin
        if (sr_rst) begin
            sr_q <= '0;
        end else begin
            case (sr_mode)
                2'b01:   sr_q <= {sr_q[W-2:0], s_in};
                2'b10:   sr_q <= {s_in, sr_q[W-1:1]};
                2'b11:   sr_q <= sr_p_in;
                default: sr_q <= sr_q;
            endcase
        end
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Final register value from the command rules: start from data (TX) or the
    // current contents (RX), then apply ln shifts of the serial bits in order.
    function automatic logic [W-1:0] model_rsp(input bit rx, input bit dir, input int ln,
                                               input logic [W-1:0] data, input logic [W-1:0] start,
                                               input logic [W-1:0] sbits);
        int r;
        r = rx ? int'(start) : int'(data);
        for (int i = 0; i < ln; i++) begin
            if (!dir) r = ((r * 2) + int'(sbits[i])) % 256;
            else      r = (r / 2) + int'(sbits[i]) * 128;
        end
        return W'(r);
    endfunction

    // Response monitor: pops the scoreboard when a response appears and holds
    // rsp_ready low for the requested number of stall cycles.
    initial begin : monitor
        exp_t cur;
        bit   in_rsp;
        int   remaining;
        in_rsp = 0;
        remaining = 0;
        cur = '{data: '0, acc: 0, lat: 0, stall: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rsp = 0;
                rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                        cur = '{data: '0, acc: cyc, lat: 0, stall: 0};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_latency", cyc - cur.acc, cur.lat);
                    end
                    chk("rsp_data", rsp_data, cur.data);
                    $display("rsp data=%02h expected=%02h latency=%0d stall=%0d",
                             rsp_data, cur.data, cyc - cur.acc, cur.stall);
                    remaining = cur.stall;
                    in_rsp = 1;
                end else begin
                    chk("rsp_hold_data", rsp_data, cur.data);
                    chk("rsp_hold_cmd_ready", cmd_ready, 0);
                    chk("rsp_hold_mode", sr_mode, 0);
                end
                if (remaining == 0) begin
                    rsp_ready = 1'b1;
                    last_hs = cyc;
                    done_cnt++;
                    in_rsp = 0;
                end else begin
                    remaining--;
                    rsp_ready = 1'b0;
                end
            end else begin
                rsp_ready = 1'b0;
            end
        end
    end

    bit expect_gap = 0;

    task automatic run_cmd(input bit rx, input bit dir, input logic [CW-1:0] len,
                           input logic [W-1:0] data, input logic [W-1:0] sbits,
                           input int stall, input bit hold);
        int   ln, offset, lastk, w, acc, target;
        exp_t e;
        ln = (len == 0 || len > W) ? W : int'(len);
        offset = rx ? 1 : 2;
        lastk = offset + ln;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        acc = cyc;
        if (expect_gap) chk("accept_gap", acc - last_hs, 1);
        cmd_valid = 1'b1;
        cmd_rx = rx;
        cmd_dir = dir;
        cmd_len = len;
        cmd_data = data;
        e.data = model_rsp(rx, dir, ln, data, sr_model, sbits);
        e.acc = acc;
        e.lat = lastk;
        e.stall = stall;
        sr_model = e.data;
        target = done_cnt + 1;
        exp_q.push_back(e);
        $display("cmd rx=%0d dir=%0d len=%0d data=%02h sbits=%02h stall=%0d hold=%0d expect=%02h",
                 rx, dir, len, data, sbits, stall, hold, e.data);
        for (int k = 1; k <= lastk; k++) begin
            @(negedge clk);
            if (hold) begin
                cmd_valid = 1'b1;
                cmd_rx = 1'($urandom);
                cmd_dir = 1'($urandom);
                cmd_len = CW'($urandom);
                cmd_data = W'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            if (!rx && k == 1) begin
                chk("mode_load", sr_mode, 2'b11);
                chk("load_p_in", sr_p_in, data);
            end else if (k < lastk) begin
                chk("mode_shift", sr_mode, dir ? 2'b10 : 2'b01);
            end else begin
                chk("mode_rsp", sr_mode, 2'b00);
            end
            if (k < lastk) begin
                chk("busy_run", busy, 1);
                chk("cmd_ready_run", cmd_ready, 0);
                chk("rsp_valid_run", rsp_valid, 0);
            end
            if (k >= offset && k < lastk) s_in = sbits[k - offset];
        end
        w = 0;
        while (done_cnt != target && w < 200) begin
            @(posedge clk);
            w++;
        end
        chk("rsp_handshake", done_cnt, target);
        #1;
        cmd_valid = 1'b0;
        expect_gap = 1;
    endtask

    task automatic reset_mid_tx();
        int w;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1;
        cmd_rx = 1'b0;
        cmd_dir = 1'($urandom);
        cmd_len = CW'(8);
        cmd_data = W'($urandom_range(1, 255));
        $display("cmd rx=0 len=8 data=%02h with reset in cycle 3 (no response expected)", cmd_data);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mode", sr_mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_p_in", sr_p_in, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sr_model = '0;
        expect_gap = 0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
    endtask

    initial begin : stimulus
        #12;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_mode", sr_mode, 0);
        chk("reset_p_in", sr_p_in, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // RX right x8 from an empty register: serial bits 1,0,1,1,0,0,1,0.
        run_cmd(1'b1, 1'b1, 4'd8, 8'h00, 8'h4D, 0, 1'b0);
        // TX left x4 of 0xA5 with zero serial input.
        run_cmd(1'b0, 1'b0, 4'd4, 8'hA5, 8'h00, 0, 1'b0);
        // Length normalisation: 0 and 12 both mean 8.
        run_cmd(1'b0, 1'b0, 4'd0, 8'h3C, 8'hF0, 0, 1'b0);
        run_cmd(1'b0, 1'b1, 4'd12, 8'hC3, 8'h0F, 0, 1'b0);
        // Response stalled 5 cycles with cmd_valid held high.
        run_cmd(1'b0, 1'b1, 4'd3, 8'h96, 8'h05, 5, 1'b1);
        run_cmd(1'b1, 1'b0, 4'd1, 8'h00, 8'h01, 0, 1'b0);

        reset_mid_tx();

        for (int n = 0; n < 25; n++) begin
            run_cmd(1'($urandom), 1'($urandom), CW'($urandom_range(0, 15)),
                    W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_ctrl.md
# shift_reg_ctrl

Command-driven sequencer for the universal shift register datapath. It accepts transmit/receive commands over a valid/ready interface and drives the register's `mode` and `p_in` for the required number of cycles: a parallel load, a shift run of programmable length and direction, then hold. It returns the final register contents on a valid/ready response channel. It sits beside the shift register in the parent; the bench and parent connect `sr_mode`/`sr_p_in`/`sr_out` to the datapath instance.

## Interface
- `WIDTH`, 8, datapath width (≥2)
- `CNT_W`, `$clog2(WIDTH+1)`, width of length field/counter (derived, do not override)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset; one clock, reset async active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller can accept (= state IDLE)
- `cmd_rx`  in  1  0 = TX (load then shift), 1 = RX (shift only, no load)
- `cmd_dir`  in  1  0 = left (mode 01), 1 = right (mode 10)
- `cmd_len`  in  CNT_W  number of shift cycles; 0 or >WIDTH → WIDTH
- `cmd_data`  in  WIDTH  parallel word for TX load
- `sr_mode`  out  2  mode to shift register
- `sr_p_in`  out  WIDTH  parallel load value to shift register
- `sr_out`  in  WIDTH  current shift register contents
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed
- `rsp_data`  out  WIDTH  = `sr_out` while `rsp_valid`, else 0
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, SHIFT, RSP. All state/registers async-cleared by `rst_n`=0.
- IDLE: `cmd_ready`=1, `sr_mode`=00. On `cmd_valid`&&`cmd_ready`, latch dir, len (normalised), data. Go to LOAD if TX, SHIFT if RX. Command fields are ignored outside acceptance.
- LOAD: `sr_mode`=11, `sr_p_in`=latched data, for exactly 1 cycle. Then go to SHIFT.
- SHIFT: `sr_mode`=01 (dir 0) or 10 (dir 1) for exactly len cycles. The counter loads len on entry and decrements each cycle. Exit to RSP when the count reaches 1.
- RSP: `sr_mode`=00 (datapath holds), `rsp_valid`=1, `rsp_data`=`sr_out`. Stay until `rsp_ready`=1, then go to IDLE.
- The controller never drives `s_in`; serial data is sourced externally.
- `sr_p_in` holds the latched data register (0 after reset). It is only meaningful in LOAD.
- Length normalisation: `len_n = (cmd_len==0 || cmd_len>WIDTH) ? WIDTH : cmd_len`.

## Timing
- Reset values: `cmd_ready`=1, `sr_mode`=00, `sr_p_in`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
- Accept edge = cycle 0.
  - TX: LOAD in cycle 1, SHIFT in cycles 2..len+1, `rsp_valid` rises in cycle len+2.
  - RX: SHIFT in cycles 1..len, `rsp_valid` in cycle len+1.
- Response handshake completes on the edge with `rsp_valid`&&`rsp_ready`. The next cycle is IDLE. The earliest next accept is that IDLE cycle, so there is a minimum one-cycle gap between commands.
- `rsp_valid` stays asserted and `rsp_data` stays stable while `rsp_ready`=0. `cmd_valid` is ignored meanwhile.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). The in-flight command is discarded, no response is produced, and the datapath contents are not restored.
- `sr_mode`, `cmd_ready`, `rsp_valid` and `busy` are decoded from registered state only; there is no combinational path from `cmd_valid`/`rsp_ready`.

## Structure
- Shared package `shift_reg_pkg`:
  - mode constants `MODE_HOLD`=2'b00, `MODE_SHL`=2'b01, `MODE_SHR`=2'b10, `MODE_LOAD`=2'b11;
  - controller state enum;
  - direction encoding.
- One sub-module: `shift_reg_len_cnt`, a loadable CNT_W down-counter with `load`, `dec` and `last` (count==1) outputs.
- The FSM, command latch and output decode stay in `shift_reg_ctrl`.

## Test plan
(WIDTH=8; bench instantiates the shift register fed by `sr_mode`/`sr_p_in`, its reset tied to `~rst_n`.)
- TX, dir 0, len 4, data 0xA5, `s_in`=0 → `sr_mode` sequence 11, 01×4, 00; `rsp_valid` in cycle 6; `rsp_data`=0x50.
- RX, dir 1, len 8, register 0x00, `s_in` per shift 1,0,1,1,0,0,1,0 → 8 cycles of mode 10; `rsp_valid` in cycle 9; `rsp_data`=0x4D.
- TX with `cmd_len`=0, then `cmd_len`=12 → each produces exactly 8 SHIFT cycles; `rsp_valid` in cycle 10.
- `rsp_ready` held low 5 cycles in RSP, `cmd_valid`=1 throughout → `rsp_valid`/`rsp_data` stable, `sr_mode`=00, `cmd_ready`=0; new command accepted only in the IDLE cycle after the handshake.
- `rst_n` pulsed low in cycle 3 of a len-8 TX → same-cycle `sr_mode`=00, `busy`=0, `rsp_valid`=0; after release `cmd_ready`=1 and no response is ever issued.
- Back-to-back TX commands with `rsp_ready`=1 → second accept exactly one cycle after the first response handshake.
